// File: rtl/restador_serie_8bits_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master side feeds operands and accepts results; the slave side is the subtractor.
interface restador_serie_8bits_if #(
  parameter int ANCHO = 8
);
  logic             inicio;
  logic             listo;
  logic             prestamo_entrada;
  logic [ANCHO-1:0] entradaA;
  logic [ANCHO-1:0] entradaB;
  logic [ANCHO-1:0] resta_salida;
  logic             prestamo_salida;
  logic             desbordamiento;
  logic             cero;
  logic             salida_valida;
  logic             acepta;

  modport master (
    output inicio, prestamo_entrada, entradaA, entradaB, acepta,
    input  listo, resta_salida, prestamo_salida, desbordamiento, cero, salida_valida
  );

  modport slave (
    input  inicio, prestamo_entrada, entradaA, entradaB, acepta,
    output listo, resta_salida, prestamo_salida, desbordamiento, cero, salida_valida
  );
endinterface

// File: rtl/restador_serie_8bits.sv
// Bit-serial subtractor: A - B - borrow_in, one bit per clock, LSB first,
// using a single borrow flip-flop; start/ready in, valid/accept out.
module restador_serie_8bits #(
  parameter int ANCHO = 8
) (
  input logic                    reloj,
  input logic                    reinicio,
  restador_serie_8bits_if.slave  bus
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CALCULO   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic [CW-1:0]    r_cnt;
  logic [ANCHO-1:0] r_a;
  logic [ANCHO-1:0] r_b;
  logic [ANCHO-1:0] r_desplaza;
  logic             r_br;
  logic [ANCHO-1:0] r_resta;
  logic             r_prestamo;
  logic             r_desb;
  logic             r_cero;
  logic             r_valida;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_sig;
  logic             w_ultimo;
  logic [ANCHO-1:0] w_res;

  // One full-subtractor cell, time-multiplexed across the operand bits.
  assign w_ai     = r_a[r_cnt];
  assign w_bi     = r_b[r_cnt];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_br_sig = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_ultimo = (r_cnt == CW'(ANCHO - 1));
  assign w_res    = {w_d, r_desplaza[ANCHO-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge reloj) begin
    if (reinicio) r_estado <= REPOSO;
    else          r_estado <= w_estado_sig;
  end

  // NOTE: default assignment first, so no path leaves w_estado_sig unassigned
  // and no latch is inferred.
  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      REPOSO:    if (bus.inicio) w_estado_sig = CALCULO;
      CALCULO:   if (w_ultimo)   w_estado_sig = RESULTADO;
      RESULTADO: if (bus.acepta) w_estado_sig = REPOSO;
      default:                   w_estado_sig = REPOSO;
    endcase
  end

  // NOTE: the synchronous reset also clears the operand and shift registers,
  // so an aborted operation leaves nothing stale behind.
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_desplaza <= '0;
      r_br       <= 1'b0;
      r_resta    <= '0;
      r_prestamo <= 1'b0;
      r_desb     <= 1'b0;
      r_cero     <= 1'b0;
      r_valida   <= 1'b0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (bus.inicio) begin
            r_a        <= bus.entradaA;
            r_b        <= bus.entradaB;
            r_br       <= bus.prestamo_entrada;
            r_desplaza <= '0;
            r_cnt      <= '0;
          end
        end
        CALCULO: begin
          r_desplaza <= w_res;
          r_br       <= w_br_sig;
          r_cnt      <= r_cnt + 1'b1;
          if (w_ultimo) begin
            r_resta    <= w_res;
            r_prestamo <= w_br_sig;
            r_desb     <= (r_a[ANCHO-1] != r_b[ANCHO-1]) && (w_res[ANCHO-1] != r_a[ANCHO-1]);
            r_cero     <= (w_res == '0);
            r_valida   <= 1'b1;
          end
        end
        RESULTADO: begin
          // Only the valid flag drops; the result and flags persist.
          if (bus.acepta) r_valida <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.listo           = (r_estado == REPOSO);
  assign bus.resta_salida    = r_resta;
  assign bus.prestamo_salida = r_prestamo;
  assign bus.desbordamiento  = r_desb;
  assign bus.cero            = r_cero;
  assign bus.salida_valida   = r_valida;

endmodule

// File: tb/tb_restador_serie_8bits.sv
// Directed self-checking bench for restador_serie_8bits: vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_restador_serie_8bits;

  logic reloj;
  logic reinicio;
  int   n_checks;
  int   n_fail;

  restador_serie_8bits_if #(.ANCHO(8)) bus ();

  restador_serie_8bits #(.ANCHO(8)) dut (
    .reloj    (reloj),
    .reinicio (reinicio),
    .bus      (bus)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_r;
    logic       exp_bo;
    logic       exp_ov;
    logic       exp_z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge reloj);
    #1;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " resta"},    32'(bus.resta_salida),    32'(v.exp_r));
    check({tag, " prestamo"}, 32'(bus.prestamo_salida), 32'(v.exp_bo));
    check({tag, " desb"},     32'(bus.desbordamiento),  32'(v.exp_ov));
    check({tag, " cero"},     32'(bus.cero),            32'(v.exp_z));
  endtask

  // Starts an op and runs it to completion; optionally accepts the result.
  task automatic run_op(input string tag, input vec_t v, input bit do_accept);
    int  cyc;
    bit  listo_alto;
    cyc = 0;
    while (!bus.listo && cyc < 30) begin
      step();
      cyc++;
    end
    check({tag, " listo before start"}, 32'(bus.listo), 32'd1);
    bus.entradaA         = v.a;
    bus.entradaB         = v.b;
    bus.prestamo_entrada = v.bin;
    bus.inicio           = 1'b1;
    step();
    bus.inicio           = 1'b0;
    bus.entradaA         = 8'($urandom);
    bus.entradaB         = 8'($urandom);
    bus.prestamo_entrada = 1'($urandom);
    cyc = 0;
    listo_alto = 1'b0;
    while (!bus.salida_valida && cyc < 30) begin
      if (bus.listo) listo_alto = 1'b1;
      step();
      cyc++;
    end
    if (bus.listo) listo_alto = 1'b1;
    check({tag, " latency"}, 32'(cyc), 32'd8);
    check({tag, " listo low while busy"}, 32'(listo_alto), 32'd0);
    check_outputs(tag, v);
    if (do_accept) begin
      bus.acepta = 1'b1;
      step();
      bus.acepta = 1'b0;
      check({tag, " valid after accept"}, 32'(bus.salida_valida), 32'd0);
      check({tag, " listo after accept"}, 32'(bus.listo), 32'd1);
      check({tag, " resta kept"}, 32'(bus.resta_salida), 32'(v.exp_r));
    end
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;

    //            a      b      bin   r      bo    ov    z
    vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    bus.inicio           = 1'b0;
    bus.acepta           = 1'b0;
    bus.entradaA         = '0;
    bus.entradaB         = '0;
    bus.prestamo_entrada = 1'b0;
    reinicio             = 1'b1;
    repeat (3) step();
    reinicio = 1'b0;
    step();

    v = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    check_outputs("reset", v);
    check("reset valid", 32'(bus.salida_valida), 32'd0);
    check("reset listo", 32'(bus.listo), 32'd1);

    // acepta outside RESULTADO must be ignored
    bus.acepta = 1'b1;
    step();
    bus.acepta = 1'b0;
    check("idle acepta listo", 32'(bus.listo), 32'd1);
    check("idle acepta valid", 32'(bus.salida_valida), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Backpressure: result held while inicio pulses with new operands.
    run_op("bp", vecs[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.inicio   = k[0] ? 1'b0 : 1'b1;
      bus.entradaA = 8'hFF;
      bus.entradaB = 8'h01;
      step();
      check($sformatf("bp valid c%0d", k), 32'(bus.salida_valida), 32'd1);
      check($sformatf("bp listo c%0d", k), 32'(bus.listo), 32'd0);
      check($sformatf("bp resta c%0d", k), 32'(bus.resta_salida), 32'h30);
    end
    bus.inicio = 1'b0;
    bus.acepta = 1'b1;
    step();
    bus.acepta = 1'b0;
    check("bp valid after accept", 32'(bus.salida_valida), 32'd0);
    check("bp listo after accept", 32'(bus.listo), 32'd1);
    check("bp resta kept", 32'(bus.resta_salida), 32'h30);
    step();
    check("bp no new op", 32'(bus.listo), 32'd1);

    // Reset on the 4th CALCULO edge aborts the operation.
    bus.entradaA         = 8'h50;
    bus.entradaB         = 8'h20;
    bus.prestamo_entrada = 1'b0;
    bus.inicio           = 1'b1;
    step();
    bus.inicio = 1'b0;
    repeat (3) step();
    check("abort busy", 32'(bus.listo), 32'd0);
    reinicio = 1'b1;
    step();
    reinicio = 1'b0;
    v = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    check_outputs("abort", v);
    check("abort valid", 32'(bus.salida_valida), 32'd0);
    check("abort listo", 32'(bus.listo), 32'd1);
    begin
      bit vista;
      vista = 1'b0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (bus.salida_valida) vista = 1'b1;
      end
      check("abort no stale valid", 32'(vista), 32'd0);
    end
    v = '{8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    run_op("post-abort", v, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1);
  end

endmodule
